// File: rtl/relogio_ajuste.sv
// Time-setting controller: debounced mode/inc buttons drive RUN/SET_H/SET_M/SET_S,
// gate the 1 Hz tick and issue one-cycle set commands plus blink masks.
module relogio_ajuste #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int REPEAT_START    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic       main_clock,
   input  logic       main_reset,
   input  logic       enable_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic       run_enable,
   output logic       set_inc_h,
   output logic       set_inc_m,
   output logic       clr_sec,
   output logic       blank_h,
   output logic       blank_m,
   output logic       blank_s,
   output logic [1:0] mode
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int RW = $clog2(REPEAT_START + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RS_LIM  = RW'(REPEAT_START);
   localparam logic [RW-1:0] RP_LIM  = RW'(REPEAT_PERIOD);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      SET_H = 2'b01,
      SET_M = 2'b10,
      SET_S = 2'b11
   } state_t;

   // bit 0 = mode button, bit 1 = increment button
   logic [1:0]         sync1_q, sync1_d;
   logic [1:0]         sync2_q, sync2_d;
   logic [1:0]         lvl_q, lvl_d;
   logic [1:0]         lvl_dly_q, lvl_dly_d;
   logic [1:0]         evt_q, evt_d;
   logic [1:0][CW-1:0] db_cnt_q, db_cnt_d;
   state_t             state_q, state_d;
   logic               phase_q, phase_d;
   logic [RW-1:0]      rep_cnt_q, rep_cnt_d;
   logic               rep_on_q, rep_on_d;
   logic               set_inc_h_q, set_inc_h_d;
   logic               set_inc_m_q, set_inc_m_d;
   logic               clr_sec_q, clr_sec_d;

   logic               mode_evt, inc_evt, chg;
   logic               rep_ok, rep_fire;
   logic [RW-1:0]      rep_lim;

   always_comb begin
      sync1_d   = {btn_inc, btn_mode};
      sync2_d   = sync1_q;
      lvl_d     = lvl_q;
      db_cnt_d  = db_cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] == lvl_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_LAST) begin
            lvl_d[i]    = sync2_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end
      end
      lvl_dly_d = lvl_q;
      evt_d     = lvl_q & ~lvl_dly_q;

      mode_evt  = evt_q[0];
      inc_evt   = evt_q[1] & ~evt_q[0];

      state_d   = mode_evt ? state_t'(state_q + 2'd1) : state_q;
      chg       = (state_d != state_q);

      phase_d   = phase_q;
      if (chg)
         phase_d = 1'b0;
      else if (enable_1hz && state_q != RUN)
         phase_d = ~phase_q;

      // a release seen at the synchronizer stops repeat without debounce lag
      rep_ok    = (state_q == SET_H || state_q == SET_M) &&
                  lvl_q[1] && sync2_q[1] && !chg;
      rep_lim   = rep_on_q ? RP_LIM : RS_LIM;
      rep_fire  = rep_ok && (rep_cnt_q != '0) && (rep_cnt_q == rep_lim);

      rep_cnt_d = rep_cnt_q;
      rep_on_d  = rep_on_q;
      if (!rep_ok) begin
         rep_cnt_d = '0;
         rep_on_d  = 1'b0;
      end else if (inc_evt) begin
         rep_cnt_d = RW'(1);
         rep_on_d  = 1'b0;
      end else if (rep_fire) begin
         rep_cnt_d = RW'(1);
         rep_on_d  = 1'b1;
      end else if (rep_cnt_q != '0) begin
         rep_cnt_d = rep_cnt_q + 1'b1;
      end

      set_inc_h_d = (state_q == SET_H) && (inc_evt || rep_fire);
      set_inc_m_d = (state_q == SET_M) && (inc_evt || rep_fire);
      clr_sec_d   = (state_q == SET_S) && inc_evt;
   end

   always_ff @(posedge main_clock) begin
      if (main_reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         lvl_q       <= '0;
         lvl_dly_q   <= '0;
         evt_q       <= '0;
         db_cnt_q    <= '0;
         state_q     <= RUN;
         phase_q     <= 1'b0;
         rep_cnt_q   <= '0;
         rep_on_q    <= 1'b0;
         set_inc_h_q <= 1'b0;
         set_inc_m_q <= 1'b0;
         clr_sec_q   <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         lvl_q       <= lvl_d;
         lvl_dly_q   <= lvl_dly_d;
         evt_q       <= evt_d;
         db_cnt_q    <= db_cnt_d;
         state_q     <= state_d;
         phase_q     <= phase_d;
         rep_cnt_q   <= rep_cnt_d;
         rep_on_q    <= rep_on_d;
         set_inc_h_q <= set_inc_h_d;
         set_inc_m_q <= set_inc_m_d;
         clr_sec_q   <= clr_sec_d;
      end
   end

   assign run_enable = enable_1hz & (state_q == RUN);
   assign set_inc_h  = set_inc_h_q;
   assign set_inc_m  = set_inc_m_q;
   assign clr_sec    = clr_sec_q;
   assign blank_h    = phase_q & (state_q == SET_H);
   assign blank_m    = phase_q & (state_q == SET_M);
   assign blank_s    = phase_q & (state_q == SET_S);
   assign mode       = state_q;

endmodule

// File: tb/tb_relogio_ajuste.sv
// Directed bench for relogio_ajuste: expected mode changes and command pulses
// are queued per press and checked cycle by cycle against the outputs.
module tb_relogio_ajuste;

   localparam int DB = 4;
   localparam int RS = 20;
   localparam int RP = 8;

   logic       clk = 1'b0;
   logic       rst, en, bm, bi;
   logic       run_enable, set_inc_h, set_inc_m, clr_sec;
   logic       blank_h, blank_m, blank_s;
   logic [1:0] mode;

   relogio_ajuste #(
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_START(RS),
      .REPEAT_PERIOD(RP)
   ) dut (
      .main_clock(clk),
      .main_reset(rst),
      .enable_1hz(en),
      .btn_mode(bm),
      .btn_inc(bi),
      .run_enable(run_enable),
      .set_inc_h(set_inc_h),
      .set_inc_m(set_inc_m),
      .clr_sec(clr_sec),
      .blank_h(blank_h),
      .blank_m(blank_m),
      .blank_s(blank_s),
      .mode(mode)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         at;
      logic [2:0] val;
   } item_t;

   item_t      cmd_q[$];
   item_t      mode_q[$];
   int         n = 0;
   int         vecs = 0;
   int         errs = 0;
   logic [1:0] exp_mode = 2'b00;
   logic       exp_phase = 1'b0;
   bit         en_on = 1'b1;
   int         k;

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, n, obs, exp);
      end
   endtask

   task automatic push_mode(input int at, input logic [1:0] m);
      item_t it;
      it.at  = at;
      it.val = {1'b0, m};
      mode_q.push_back(it);
   endtask

   task automatic push_cmd(input int at, input logic [2:0] c);
      item_t it;
      it.at  = at;
      it.val = c;
      cmd_q.push_back(it);
   endtask

   task automatic step();
      logic [1:0] prev;
      logic [2:0] ecmd;
      logic       rst_s, en_s;
      logic [2:0] eblank;
      rst_s = rst;
      en_s  = en;
      @(posedge clk);
      #1;
      n++;
      prev = exp_mode;
      ecmd = 3'b000;
      if (rst_s) begin
         cmd_q.delete();
         mode_q.delete();
         exp_mode  = 2'b00;
         exp_phase = 1'b0;
      end else begin
         if (mode_q.size() > 0 && mode_q[0].at == n) begin
            exp_mode = mode_q[0].val[1:0];
            void'(mode_q.pop_front());
         end
         if (exp_mode != prev)
            exp_phase = 1'b0;
         else if (en_s && prev != 2'b00)
            exp_phase = ~exp_phase;
         if (cmd_q.size() > 0 && cmd_q[0].at == n) begin
            ecmd = cmd_q[0].val;
            void'(cmd_q.pop_front());
         end
      end
      eblank = {exp_phase && exp_mode == 2'd1,
                exp_phase && exp_mode == 2'd2,
                exp_phase && exp_mode == 2'd3};
      chk("mode", {2'b00, mode}, {2'b00, exp_mode});
      chk("cmd", {1'b0, set_inc_h, set_inc_m, clr_sec}, {1'b0, ecmd});
      chk("blank", {1'b0, blank_h, blank_m, blank_s}, {1'b0, eblank});
      chk("run_en", {3'b000, run_enable}, {3'b000, en_s && exp_mode == 2'b00});
      en = en_on && ((n + 1) % 10 == 0);
   endtask

   task automatic steps(input int cnt);
      repeat (cnt) step();
   endtask

   task automatic mode_press(input logic [1:0] next);
      k  = n;
      bm = 1'b1;
      push_mode(k + DB + 4, next);
      steps(10);
      bm = 1'b0;
      steps(15);
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      bm  = 1'b0;
      bi  = 1'b0;
      steps(3);
      rst = 1'b0;
      steps(30);

      // short glitch on mode is rejected
      bm = 1'b1;
      steps(3);
      bm = 1'b0;
      steps(15);

      mode_press(2'd1);

      // held increment in SET_H: first pulse, then repeat
      k  = n;
      bi = 1'b1;
      push_cmd(k + 8, 3'b100);
      push_cmd(k + 8 + RS, 3'b100);
      push_cmd(k + 8 + RS + RP, 3'b100);
      steps(40);
      bi = 1'b0;
      steps(25);

      mode_press(2'd2);
      k  = n;
      bi = 1'b1;
      push_cmd(k + 8, 3'b010);
      steps(6);
      bi = 1'b0;
      steps(15);

      mode_press(2'd3);
      // long hold in SET_S still gives a single clear
      k  = n;
      bi = 1'b1;
      push_cmd(k + 8, 3'b001);
      steps(30);
      bi = 1'b0;
      steps(15);

      mode_press(2'd0);
      steps(20);
      mode_press(2'd1);
      mode_press(2'd2);

      // simultaneous press: mode wins, inc dropped
      k  = n;
      bm = 1'b1;
      bi = 1'b1;
      push_mode(k + 8, 2'd3);
      steps(10);
      bm = 1'b0;
      bi = 1'b0;
      steps(15);

      mode_press(2'd0);
      mode_press(2'd1);
      mode_press(2'd2);

      // reset during an active repeat in SET_M
      k  = n;
      bi = 1'b1;
      push_cmd(k + 8, 3'b010);
      push_cmd(k + 8 + RS, 3'b010);
      steps(31);
      rst = 1'b1;
      bm  = 1'b1;
      steps(2);
      rst = 1'b0;
      k   = n;
      push_mode(k + DB + 4, 2'd1);
      steps(12);
      bm = 1'b0;
      bi = 1'b0;
      steps(20);

      chk("sb_empty", 4'(cmd_q.size() + mode_q.size()), 4'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
